wta_spike_arbiter: RTL and testbench

- Sits directly downstream of the array of winner-take-all Izhikevich neurons; consumes one SPIKE bit per neuron per CLK (one CLK = one integration step).
- Selects a single winner among simultaneous spikes.
- Drives per-neuron INHIBIT lines, which are wired back as each neuron's lateral-inhibition input, for a programmable window.
- Logs every accepted spike as an address-event (neuron id + timestamp) into a small FIFO read out through a valid/ready handshake.

---
 rtl/snn_pkg.sv | 39 +++
 rtl/aer_event_fifo.sv | 73 +++++++
 rtl/wta_spike_arbiter.sv | 142 ++++++++++++++
 tb/tb_wta_spike_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared types and helpers for the winner-take-all spike arbiter.
//   wta_state_t    : arbiter state (IDLE, INH)
//   aer_evt_t      : address-event {id, ts}, sized for the widest supported
//                    configuration; narrower instances zero-extend into it
//   lowest_set_idx : index of the lowest set bit (0 when the vector is zero)
// ---------------------------------------------------------------------------
package snn_pkg;

    localparam int unsigned AER_ID_MAX_W = 8;
    localparam int unsigned AER_TS_MAX_W = 32;
    localparam int unsigned SPIKE_MAX_N  = 32;

    typedef enum logic [0:0] {
        IDLE,
        INH
    } wta_state_t;

    typedef struct packed {
        logic [AER_ID_MAX_W-1:0] id;
        logic [AER_TS_MAX_W-1:0] ts;
    } aer_evt_t;

    // Scan from the top down so the last hit is the lowest index.
    function automatic logic [AER_ID_MAX_W-1:0] lowest_set_idx(
        input logic [SPIKE_MAX_N-1:0] vec
    );
        logic [AER_ID_MAX_W-1:0] idx;
        idx = '0;
        for (int i = SPIKE_MAX_N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = AER_ID_MAX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// ---------------------------------------------------------------------------
// aer_event_fifo
// Synchronous FIFO of address-events, no bypass.
//   CLK, RST   : clock, asynchronous active-high reset (empties the FIFO)
//   i_push     : write i_evt; ignored when full unless a pop happens too
//   i_evt      : event to write
//   i_pop      : remove head; ignored when empty
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_head     : oldest entry, all zeros when empty
// ---------------------------------------------------------------------------
module aer_event_fifo
    import snn_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     i_push,
    input  aer_evt_t i_evt,
    input  logic     i_pop,
    output logic     o_full,
    output logic     o_empty,
    output aer_evt_t o_head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    aer_evt_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty = (r_count == '0);

    // A pop frees the slot this push needs, so full + pop still accepts.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers decide what is visible.
    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_evt;
        end
    end

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/wta_spike_arbiter.sv
// ---------------------------------------------------------------------------
// wta_spike_arbiter
// Picks one winner among simultaneous neuron spikes, inhibits all other
// neurons for INH_CYCLES steps, and logs accepted spikes as {id, ts} events.
//   CLK, RST      : step clock, asynchronous active-high reset
//   SPIKE_IN      : one spike bit per neuron, sampled at posedge CLK
//   INHIBIT       : lateral inhibition, all ones except the winner while active
//   WINNER_VALID  : inhibition window active
//   WINNER_ID     : current winner index
//   EVT_VALID/EVT_READY/EVT_ID/EVT_TS : event FIFO head handshake
//   OVERFLOW      : sticky, an event was dropped on a full FIFO
// ---------------------------------------------------------------------------
module wta_spike_arbiter
    import snn_pkg::*;
#(
    parameter int unsigned N          = 10,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned TS_W       = 16,
    parameter int unsigned INH_CYCLES = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N-1:0]    SPIKE_IN,
    output logic [N-1:0]    INHIBIT,
    output logic            WINNER_VALID,
    output logic [ID_W-1:0] WINNER_ID,
    output logic            EVT_VALID,
    input  logic            EVT_READY,
    output logic [ID_W-1:0] EVT_ID,
    output logic [TS_W-1:0] EVT_TS,
    output logic            OVERFLOW
);

    localparam int unsigned CNT_W = $clog2(INH_CYCLES + 1);

    wta_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [ID_W-1:0]  r_winner_id;
    logic             r_winner_valid;
    logic [N-1:0]     r_inhibit;
    logic [TS_W-1:0]  r_ts;
    logic             r_overflow;

    logic            w_any;
    logic [ID_W-1:0] w_low_idx;
    logic [N-1:0]    w_low_onehot;
    logic            w_respawn;
    logic            w_accept;
    logic [ID_W-1:0] w_evt_id;
    aer_evt_t        w_push_evt;
    aer_evt_t        w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;

    assign w_any        = |SPIKE_IN;
    assign w_low_idx    = ID_W'(lowest_set_idx(SPIKE_MAX_N'(SPIKE_IN)));
    assign w_low_onehot = N'(1) << w_low_idx;

    // In INH the only clear bit of r_inhibit is the winner, so this picks
    // out a spike from the current winner without a variable bit select.
    assign w_respawn = (r_state == INH) && |(SPIKE_IN & ~r_inhibit);
    assign w_accept  = (r_state == IDLE) ? w_any : w_respawn;
    assign w_evt_id  = (r_state == IDLE) ? w_low_idx : r_winner_id;

    always_comb begin
        w_push_evt    = '0;
        w_push_evt.id = AER_ID_MAX_W'(w_evt_id);
        w_push_evt.ts = AER_TS_MAX_W'(r_ts);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_winner_id    <= '0;
            r_winner_valid <= 1'b0;
            r_inhibit      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state        <= INH;
                        r_cnt          <= CNT_W'(INH_CYCLES);
                        r_winner_id    <= w_low_idx;
                        r_winner_valid <= 1'b1;
                        r_inhibit      <= ~w_low_onehot;
                    end
                end
                INH: begin
                    if (w_respawn) begin
                        r_cnt <= CNT_W'(INH_CYCLES);
                    end else if (r_cnt == CNT_W'(1)) begin
                        r_state        <= IDLE;
                        r_cnt          <= '0;
                        r_winner_valid <= 1'b0;
                        r_inhibit      <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ts       <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            if (w_accept && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_pop = EVT_VALID && EVT_READY;

    aer_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_accept),
        .i_evt   (w_push_evt),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign INHIBIT      = r_inhibit;
    assign WINNER_VALID = r_winner_valid;
    assign WINNER_ID    = r_winner_id;
    assign EVT_VALID    = !w_empty;
    assign EVT_ID       = ID_W'(w_head.id);
    assign EVT_TS       = TS_W'(w_head.ts);
    assign OVERFLOW     = r_overflow;

endmodule

// File: tb/tb_wta_spike_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wta_spike_arbiter
// Directed stimulus; expected events are queued when a spike is issued and a
// monitor pops and compares them whenever the consumer handshake fires.
// A second instance with a 4-bit timestamp covers counter wrap.
// ---------------------------------------------------------------------------
module tb_wta_spike_arbiter;

    localparam int unsigned N    = 10;
    localparam int unsigned ID_W = 4;
    localparam int unsigned TS_W = 16;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    SPIKE_IN;
    logic [N-1:0]    INHIBIT;
    logic            WINNER_VALID;
    logic [ID_W-1:0] WINNER_ID;
    logic            EVT_VALID;
    logic            EVT_READY;
    logic [ID_W-1:0] EVT_ID;
    logic [TS_W-1:0] EVT_TS;
    logic            OVERFLOW;

    logic            rst2;
    logic [N-1:0]    spike2;
    logic [N-1:0]    inhibit2;
    logic            wvalid2;
    logic [ID_W-1:0] wid2;
    logic            evalid2;
    logic            eready2;
    logic [ID_W-1:0] eid2;
    logic [3:0]      ets2;
    logic            ovf2;

    always #5 CLK = ~CLK;

    wta_spike_arbiter #(
        .N(N), .ID_W(ID_W), .TS_W(TS_W), .INH_CYCLES(8), .FIFO_DEPTH(8)
    ) dut (
        .CLK(CLK), .RST(RST), .SPIKE_IN(SPIKE_IN), .INHIBIT(INHIBIT),
        .WINNER_VALID(WINNER_VALID), .WINNER_ID(WINNER_ID),
        .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_ID(EVT_ID),
        .EVT_TS(EVT_TS), .OVERFLOW(OVERFLOW)
    );

    wta_spike_arbiter #(
        .N(N), .ID_W(ID_W), .TS_W(4), .INH_CYCLES(8), .FIFO_DEPTH(8)
    ) dut_wrap (
        .CLK(CLK), .RST(rst2), .SPIKE_IN(spike2), .INHIBIT(inhibit2),
        .WINNER_VALID(wvalid2), .WINNER_ID(wid2),
        .EVT_VALID(evalid2), .EVT_READY(eready2), .EVT_ID(eid2),
        .EVT_TS(ets2), .OVERFLOW(ovf2)
    );

    typedef struct {
        int id;
        int ts;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ts_now   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Inputs change 1 time unit after the active edge.
    task automatic step();
        @(posedge CLK);
        #1;
        ts_now++;
    endtask

    task automatic goto_ts(input int t);
        while (ts_now < t) step();
    endtask

    task automatic spike_at(input int t, input int nrn, input bit logged);
        goto_ts(t);
        SPIKE_IN = N'(1) << nrn;
        if (logged) exp_q.push_back('{id: nrn, ts: t});
        step();
        SPIKE_IN = '0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        exp_q.delete();
        repeat (3) step();
        RST = 1'b0;
        ts_now = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_inhibit"}, INHIBIT, 0);
        check({tag, "_winner_valid"}, WINNER_VALID, 0);
        check({tag, "_winner_id"}, WINNER_ID, 0);
        check({tag, "_evt_valid"}, EVT_VALID, 0);
        check({tag, "_evt_id"}, EVT_ID, 0);
        check({tag, "_evt_ts"}, EVT_TS, 0);
        check({tag, "_overflow"}, OVERFLOW, 0);
    endtask

    // Monitor: handshake seen at a negedge completes on the next posedge.
    initial begin
        logic            hold;
        logic [ID_W-1:0] hid;
        logic [TS_W-1:0] hts;
        exp_t            e;
        hold = 1'b0;
        hid  = '0;
        hts  = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("head_hold_valid", EVT_VALID, 1);
                    check("head_hold_id", EVT_ID, hid);
                    check("head_hold_ts", EVT_TS, hts);
                end
                if (EVT_VALID && EVT_READY) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_event: got id %0d ts %0d, required no event",
                                 EVT_ID, EVT_TS);
                    end else begin
                        e = exp_q.pop_front();
                        check("evt_id", EVT_ID, e.id);
                        check("evt_ts", EVT_TS, e.ts);
                    end
                end
                hold = EVT_VALID && !EVT_READY;
                hid  = EVT_ID;
                hts  = EVT_TS;
            end
        end
    end

    initial begin
        RST       = 1'b1;
        SPIKE_IN  = '1;
        EVT_READY = 1'b0;
        rst2      = 1'b1;
        spike2    = '0;
        eready2   = 1'b0;

        // Reset held with every neuron spiking.
        #1;
        check_idle_outputs("reset0");
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle_outputs("reset_hold");
        end
        RST      = 1'b0;
        SPIKE_IN = '0;
        ts_now   = 0;
        check_idle_outputs("release");
        step();
        check_idle_outputs("release_1");

        // Single winner with a simultaneous loser (neurons 2 and 5).
        EVT_READY = 1'b1;
        goto_ts(5);
        SPIKE_IN = 10'b0000100100;
        exp_q.push_back('{id: 2, ts: 5});
        step();
        SPIKE_IN = '0;
        for (int i = 0; i < 8; i++) begin
            check("win1_valid", WINNER_VALID, 1);
            check("win1_id", WINNER_ID, 2);
            check("win1_inhibit", INHIBIT, 10'h3FB);
            step();
        end
        check("win1_end_valid", WINNER_VALID, 0);
        check("win1_end_inhibit", INHIBIT, 0);
        repeat (4) step();
        check("win1_drained", exp_q.size(), 0);

        // Respawn by the winner, other neuron ignored.
        do_reset();
        spike_at(10, 3, 1'b1);
        spike_at(12, 7, 1'b0);
        spike_at(14, 3, 1'b1);
        goto_ts(22);
        check("respawn_valid_22", WINNER_VALID, 1);
        check("respawn_id_22", WINNER_ID, 3);
        check("respawn_inhibit_22", INHIBIT, 10'h3F7);
        step();
        check("respawn_valid_23", WINNER_VALID, 0);
        repeat (4) step();
        check("respawn_drained", exp_q.size(), 0);

        // Backpressure: 9 winners, only 8 fit.
        do_reset();
        EVT_READY = 1'b0;
        for (int k = 0; k < 8; k++) spike_at(2 + 9 * k, k, 1'b1);
        goto_ts(74);
        check("bp_overflow_before", OVERFLOW, 0);
        spike_at(74, 8, 1'b0);
        check("bp_overflow_set", OVERFLOW, 1);
        check("bp_head_valid", EVT_VALID, 1);
        check("bp_head_id", EVT_ID, 0);
        check("bp_head_ts", EVT_TS, 2);
        repeat (5) step();
        check("bp_overflow_sticky", OVERFLOW, 1);
        EVT_READY = 1'b1;
        repeat (12) step();
        check("bp_drained", exp_q.size(), 0);
        check("bp_overflow_after", OVERFLOW, 1);
        check("bp_empty_valid", EVT_VALID, 0);
        check("bp_empty_id", EVT_ID, 0);
        check("bp_empty_ts", EVT_TS, 0);

        // Full FIFO: push and pop in the same cycle.
        do_reset();
        EVT_READY = 1'b0;
        for (int k = 0; k < 8; k++) spike_at(2 + 9 * k, k, 1'b1);
        goto_ts(74);
        EVT_READY = 1'b1;
        spike_at(74, 8, 1'b1);
        EVT_READY = 1'b0;
        check("pp_overflow", OVERFLOW, 0);
        check("pp_head_id", EVT_ID, 1);
        EVT_READY = 1'b1;
        repeat (12) step();
        check("pp_drained", exp_q.size(), 0);
        check("pp_overflow_after", OVERFLOW, 0);

        // Reset in the middle of a window with 3 events queued.
        do_reset();
        EVT_READY = 1'b0;
        spike_at(2, 1, 1'b1);
        spike_at(11, 2, 1'b1);
        spike_at(20, 3, 1'b1);
        goto_ts(22);
        check("mid_pre_window", WINNER_VALID, 1);
        check("mid_pre_evt_valid", EVT_VALID, 1);
        RST = 1'b1;
        exp_q.delete();
        #1;
        check("mid_async_inhibit", INHIBIT, 0);
        check("mid_async_winner_valid", WINNER_VALID, 0);
        check("mid_async_evt_valid", EVT_VALID, 0);
        repeat (2) step();
        RST       = 1'b0;
        ts_now    = 0;
        EVT_READY = 1'b1;
        repeat (4) step();
        check("mid_after_evt_valid", EVT_VALID, 0);
        check("mid_after_winner_valid", WINNER_VALID, 0);

        // Timestamp wrap on the 4-bit instance: ts 15, then 1 after wrap.
        rst2 = 1'b0;
        repeat (15) step();
        spike2 = N'(1) << 4;
        step();
        spike2 = '0;
        repeat (17) step();
        spike2 = N'(1) << 6;
        step();
        spike2 = '0;
        check("wrap_valid", evalid2, 1);
        check("wrap_first_id", eid2, 4);
        check("wrap_first_ts", ets2, 15);
        eready2 = 1'b1;
        step();
        eready2 = 1'b0;
        check("wrap_second_id", eid2, 6);
        check("wrap_second_ts", ets2, 1);
        eready2 = 1'b1;
        step();
        check("wrap_empty", evalid2, 0);
        check("wrap_overflow", ovf2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
